// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder: recovers the 16-bit value shown on a 4-digit multiplexed
// seven-segment display by sampling each settled digit and decoding it to hex.
module ssd_scan_decoder #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 200000,
    parameter int CNT_W   = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  C,
    input  logic [3:0]  AN,
    output logic [15:0] number,
    output logic        valid,
    output logic        digit_err,
    output logic        multi_an_err,
    output logic        stale
);
    typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_HELD} state_t;

    state_t             state, state_n;
    logic [3:0]         an_q, an_p, cap, cap_n, mask;
    logic [6:0]         c_q;
    logic [CNT_W-1:0]   cnt, cnt_n, tcnt;
    logic [15:0]        shadow;
    logic [3:0]         nib;
    logic               bad, ferr, sample, one_hot, multi, full, clr;

    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h40: decode = 5'h00;
            7'h79: decode = 5'h01;
            7'h24: decode = 5'h02;
            7'h30: decode = 5'h03;
            7'h19: decode = 5'h04;
            7'h12: decode = 5'h05;
            7'h02: decode = 5'h06;
            7'h78: decode = 5'h07;
            7'h00: decode = 5'h08;
            7'h10: decode = 5'h09;
            7'h08: decode = 5'h0A;
            7'h03: decode = 5'h0B;
            7'h46: decode = 5'h0C;
            7'h21: decode = 5'h0D;
            7'h06: decode = 5'h0E;
            7'h0E: decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    assign {bad, nib} = decode(c_q);
    assign one_hot    = an_q inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
    assign multi      = !one_hot && an_q != 4'hF;
    assign full       = mask == 4'hF;
    // a completing frame and an illegal AN in the same cycle both empty the mask
    assign clr        = full || multi;
    assign stale      = tcnt == CNT_W'(TIMEOUT);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cap_n   = cap;
        sample  = 1'b0;
        if (state == S_WAIT || an_q != cap) begin
            state_n = one_hot ? S_SETTLE : S_WAIT;
            cnt_n   = one_hot ? CNT_W'(1) : '0;
            cap_n   = an_q;
        end else if (state == S_SETTLE) begin
            cnt_n   = cnt + 1'b1;
            sample  = cnt == CNT_W'(SETTLE - 1);
            state_n = sample ? S_HELD : S_SETTLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q         <= 4'hF;
            an_p         <= 4'hF;
            c_q          <= 7'h7F;
            state        <= S_WAIT;
            cnt          <= '0;
            cap          <= 4'hF;
            mask         <= '0;
            ferr         <= 1'b0;
            shadow       <= '0;
            tcnt         <= '0;
            number       <= '0;
            valid        <= 1'b0;
            digit_err    <= 1'b0;
            multi_an_err <= 1'b0;
        end else begin
            an_q         <= AN;
            c_q          <= C;
            an_p         <= an_q;
            state        <= state_n;
            cnt          <= cnt_n;
            cap          <= cap_n;
            multi_an_err <= multi && an_q != an_p;
            valid        <= full;
            mask         <= (clr ? 4'h0 : mask) | (sample ? ~cap : 4'h0);
            ferr         <= (!clr && ferr) || (sample && bad);
            tcnt         <= full ? '0 : stale ? tcnt : tcnt + 1'b1;
            if (full) begin
                number    <= shadow;
                digit_err <= ferr;
            end
            if (sample)
                for (int i = 0; i < 4; i++)
                    if (!cap[i]) shadow[4*i +: 4] <= nib;
        end
    end
endmodule

// File: doc/ssd_scan_decoder.md
Name: ssd_scan_decoder

Overview:
- Receiving end of the four-digit multiplexed seven-segment interface (C, AN) driven by the board display scanner.
- Watches the anode scan, samples the cathode pattern once per digit after it settles, and decodes each pattern back to a hex nibble.
- Reassembles the 16-bit displayed number.
- Used in simulation benches and on-board self-check to confirm that the shown PC or register value matches the pipeline's internal value.

Parameters:
SETTLE, 4, cycles AN must hold one stable legal value before C is sampled
TIMEOUT, 200000, cycles without a completed frame before stale asserts
CNT_W, 18, width of the settle and timeout counters

Ports:
clk  input  1  system clock, same domain as the display scanner (50 MHz on board)
rst_n  input  1  asynchronous active-low reset
C  input  7  cathodes, active-low; C[0]=a ... C[6]=g
AN  input  4  anodes, active-low one-hot; AN[3] = digit for number[15:12], AN[0] = number[3:0]
number  output  16  last completely captured frame
valid  output  1  one-cycle pulse when number updates
digit_err  output  1  sticky per frame; some digit in the frame had a non-hex pattern
multi_an_err  output  1  one-cycle pulse when more than one AN bit is low
stale  output  1  high while no frame has completed for TIMEOUT cycles

Behaviour:
- Reset (asynchronous, rst_n=0):
  - number=0, valid=0, digit_err=0, multi_an_err=0, stale=0.
  - Captured-digit mask=0000, settle counter=0, timeout counter=0, FSM in WAIT.
- Input registering: AN and C are registered once (an_q, c_q). All decisions use the registered values, so latency from pins is +1 cycle.
- Legal AN values: exactly one bit low. 1111 (blank) is ignored: FSM goes to WAIT and the settle counter clears, with no error. Two or more low bits:
  - multi_an_err pulses for the first cycle of that value.
  - Mask clears, FSM goes to WAIT, the partial frame is discarded.
- FSM:
  - WAIT: on a legal an_q, load the settle counter with 1 and go to SETTLE.
  - SETTLE: if an_q changes, restart the count on the new value (or go to WAIT if it is illegal). When the counter reaches SETTLE with an_q unchanged, sample c_q and go to HELD.
  - HELD: remain until an_q differs from the captured value, then re-evaluate as in WAIT in that same cycle.
- Decode at sample time, active-low pattern {g,f,e,d,c,b,a} in hex:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - Any other pattern stores nibble 0 and sets the frame's error flag.
- Frame assembly:
  - The nibble is written to the shadow slot for that AN position and the mask bit is set. Recapturing a digit already in the mask overwrites the slot with no error.
  - The cycle after the mask becomes 1111: number ← shadow, valid=1 for one cycle, digit_err ← frame error flag. Then mask, error flag and timeout counter clear.
- Timeout:
  - The counter increments every cycle and saturates at TIMEOUT.
  - stale=1 while the counter equals TIMEOUT.
  - stale clears in the same cycle valid pulses.
- Simultaneous events:
  - An illegal AN in the cycle a frame would complete: the completion fires, using the already-full mask. The clear from the illegal AN applies after it.
  - Reset mid-frame discards all partial state.

Test Plan:
- Scan 0x1A2F; AN cycles 0111→1011→1101→1110, each held 16 cycles with the matching cathodes (79, 08, 24, 0E) -> exactly one valid pulse, number=16'h1A2F, digit_err=0.
- Same scan but AN=1101 held only SETTLE-1 cycles before moving on -> no valid pulse during that pass. The next full pass yields valid and number=1A2F.
- Scan with digit AN=1110 showing C=7F (all off) -> valid pulses, number=16'h1A20, digit_err=1. The next clean frame clears digit_err.
- Inject AN=0011 for one cycle mid-frame -> multi_an_err pulses once, the partial frame is discarded, and the next valid appears only after four fresh captures.
- Drive AN=1111 for TIMEOUT+5 cycles -> stale rises exactly TIMEOUT cycles after the last valid (or reset) and falls with the next valid.
- Assert rst_n=0 after two digits of a frame, then release -> all outputs are 0 and a full four-digit frame is required before valid.
